// File: rtl/follower_obstacle.sv
// follower_obstacle
// One falling obstacle in the follower lane. Each move tick moves it down by
// MOVE_AMT. When it reaches the bottom it retires, stays off screen for
// SPAWN_GAP ticks, and then respawns at the top at a pseudo-random x taken
// from a free-running LFSR. It also gives a one-cycle hit pulse on the first
// overlap with the player sprite during each pass.
//
// Ports:
//   clk            pixel clock
//   reset          synchronous, active-high
//   move_followers one-cycle move tick from the scroll controller
//   player_x/y     player sprite top-left corner
//   obs_x/obs_y    obstacle top-left corner (registered)
//   obs_active     obstacle is on screen and should be drawn
//   respawned      one-cycle pulse after a spawn has been loaded
//   hit            one-cycle pulse on the first overlap of a pass
module follower_obstacle #(
   parameter int          MOVE_AMT      = 2,
   parameter int          SCREEN_HEIGHT = 480,
   parameter int          SCREEN_WIDTH  = 640,
   parameter int          OBS_W         = 32,
   parameter int          OBS_H         = 16,
   parameter int          PLAYER_SIZE   = 16,
   parameter int          SPAWN_GAP     = 20,
   parameter int          START_Y       = 0,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       move_followers,
   input  logic [9:0] player_x,
   input  logic [9:0] player_y,
   output logic [9:0] obs_x,
   output logic [9:0] obs_y,
   output logic       obs_active,
   output logic       respawned,
   output logic       hit
);

   localparam int GW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam logic [9:0] X_SPAN = 10'(SCREEN_WIDTH - OBS_W);

   typedef enum logic [1:0] {ST_SPAWN, ST_ACTIVE, ST_WAIT} state_t;

   state_t        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [GW-1:0] gap_ctr_q, gap_ctr_d;
   logic          armed_q, armed_d;
   logic [9:0]    obs_x_q, obs_x_d;
   logic [9:0]    obs_y_q, obs_y_d;
   logic          obs_active_q, obs_active_d;
   logic          respawned_q, respawned_d;
   logic          hit_q, hit_d;

   logic [9:0]    spawn_x;
   logic [10:0]   y_next;
   logic          overlap;

   // Fold the LFSR value into [0, SCREEN_WIDTH-OBS_W). One subtraction is
   // enough because a 10-bit value is always less than twice the span.
   assign spawn_x = (lfsr_q[9:0] >= X_SPAN) ? (lfsr_q[9:0] - X_SPAN) : lfsr_q[9:0];
   assign y_next  = {1'b0, obs_y_q} + 11'(MOVE_AMT);

   // The bounding-box test is done in 11 bits so the right and bottom edges
   // cannot wrap near the edge of the screen.
   assign overlap = obs_active_q
                  && ({1'b0, player_x} < ({1'b0, obs_x_q} + 11'(OBS_W)))
                  && ({1'b0, obs_x_q}  < ({1'b0, player_x} + 11'(PLAYER_SIZE)))
                  && ({1'b0, player_y} < ({1'b0, obs_y_q} + 11'(OBS_H)))
                  && ({1'b0, obs_y_q}  < ({1'b0, player_y} + 11'(PLAYER_SIZE)));

   always_comb begin
      state_d      = state_q;
      gap_ctr_d    = gap_ctr_q;
      armed_d      = armed_q;
      obs_x_d      = obs_x_q;
      obs_y_d      = obs_y_q;
      obs_active_d = obs_active_q;
      respawned_d  = 1'b0;

      // Galois LFSR, right shift, taps 16'hB400; runs every cycle.
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

      // The overlap test uses the position before this edge's move. After a
      // hit, armed stays clear until the next spawn, so each pass gives at
      // most one pulse.
      hit_d = overlap & armed_q;
      if (hit_d) armed_d = 1'b0;

      case (state_q)
         ST_SPAWN: begin
            obs_x_d      = spawn_x;
            obs_y_d      = 10'(START_Y);
            obs_active_d = 1'b1;
            armed_d      = 1'b1;
            respawned_d  = 1'b1;
            state_d      = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (move_followers) begin
               if (y_next >= 11'(SCREEN_HEIGHT)) begin
                  obs_active_d = 1'b0;
                  obs_y_d      = 10'd0;
                  gap_ctr_d    = '0;
                  armed_d      = 1'b0;
                  state_d      = ST_WAIT;
               end else begin
                  obs_y_d = y_next[9:0];
               end
            end
         end
         ST_WAIT: begin
            if (move_followers) begin
               if (gap_ctr_q == GW'(SPAWN_GAP - 1)) state_d = ST_SPAWN;
               else gap_ctr_d = gap_ctr_q + 1'b1;
            end
         end
         default: state_d = ST_SPAWN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_SPAWN;
         lfsr_q       <= LFSR_SEED;
         gap_ctr_q    <= '0;
         armed_q      <= 1'b0;
         obs_x_q      <= 10'd0;
         obs_y_q      <= 10'd0;
         obs_active_q <= 1'b0;
         respawned_q  <= 1'b0;
         hit_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         gap_ctr_q    <= gap_ctr_d;
         armed_q      <= armed_d;
         obs_x_q      <= obs_x_d;
         obs_y_q      <= obs_y_d;
         obs_active_q <= obs_active_d;
         respawned_q  <= respawned_d;
         hit_q        <= hit_d;
      end
   end

   assign obs_x      = obs_x_q;
   assign obs_y      = obs_y_q;
   assign obs_active = obs_active_q;
   assign respawned  = respawned_q;
   assign hit        = hit_q;

endmodule

// File: tb/tb_follower_obstacle.sv
module tb_follower_obstacle;

   logic       clk = 1'b0;
   logic       reset;
   logic       move_followers;
   logic [9:0] player_x, player_y;
   logic [9:0] obs_x, obs_y;
   logic       obs_active, respawned, hit;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       exact;
      logic [9:0] x;
   } spawn_exp_t;

   spawn_exp_t sp_q[$];
   int         hit_q[$];
   logic       hit_prev = 1'b0;

   follower_obstacle dut (
      .clk(clk), .reset(reset), .move_followers(move_followers),
      .player_x(player_x), .player_y(player_y),
      .obs_x(obs_x), .obs_y(obs_y), .obs_active(obs_active),
      .respawned(respawned), .hit(hit)
   );

   always #5 clk = ~clk;

   // Monitor: every respawn or hit pulse must match an expectation that the
   // stimulus queued.
   always @(negedge clk) begin
      if (respawned) begin
         total++;
         if (sp_q.size() == 0) begin
            bad++;
            $display("FAIL spawn_unexpected: respawned=1 with nothing expected (x=%0d)", obs_x);
         end else begin
            spawn_exp_t e;
            e = sp_q.pop_front();
            if (e.exact ? (obs_x != e.x) : (obs_x > 10'd607)) begin
               bad++;
               $display("FAIL spawn_x: got %0d want %s%0d", obs_x, e.exact ? "" : "<=", e.exact ? e.x : 10'd607);
            end
            total++;
            if (obs_y != 10'd0 || !obs_active) begin
               bad++;
               $display("FAIL spawn_pos: got y=%0d act=%0d want y=0 act=1", obs_y, obs_active);
            end
         end
      end
      if (hit) begin
         total++;
         if (hit_prev) begin
            bad++;
            $display("FAIL hit_width: hit high for 2+ cycles, want 1");
         end else if (hit_q.size() == 0) begin
            bad++;
            $display("FAIL hit_unexpected: got hit=1 want 0 (x=%0d y=%0d)", obs_x, obs_y);
         end else begin
            void'(hit_q.pop_front());
         end
      end
      hit_prev <= hit;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   // Drive a tick for one cycle; returns #1 after the edge that sampled it.
   task automatic tick();
      cyc();
      move_followers = 1'b1;
      cyc();
      move_followers = 1'b0;
   endtask

   task automatic push_spawn(input logic exact, input logic [9:0] x);
      spawn_exp_t e;
      e.exact = exact;
      e.x     = x;
      sp_q.push_back(e);
   endtask

   task automatic player_away();
      player_x = 10'd1000;
      player_y = 10'd1000;
   endtask

   // From an active obstacle at y=0: 239 ticks reach 478, and the 240th retires it.
   task automatic retire_from_top();
      for (int i = 0; i < 239; i++) tick();
      chk("y_at_478", obs_y, 478);
      chk("active_at_478", obs_active, 1);
      tick();
      chk("retire_active", obs_active, 0);
      chk("retire_y", obs_y, 0);
   endtask

   // From WAIT with gap_ctr=0: 19 ticks stay inactive, the 20th reloads a spawn.
   task automatic gap_and_respawn(input string tag);
      for (int i = 0; i < 19; i++) tick();
      chk({tag, "_gap19_inactive"}, obs_active, 0);
      push_spawn(1'b0, 10'd0);
      tick();
      chk({tag, "_spawn_edge_inactive"}, obs_active, 0);
      chk({tag, "_spawn_edge_no_pulse"}, respawned, 0);
      cyc();
      chk({tag, "_respawn_active"}, obs_active, 1);
      chk({tag, "_respawn_pulse"}, respawned, 1);
      chk({tag, "_respawn_y"}, obs_y, 0);
   endtask

   initial begin
      reset = 1'b1;
      move_followers = 1'b0;
      player_away();

      // Reset values
      repeat (2) cyc();
      chk("rst_x", obs_x, 0);
      chk("rst_y", obs_y, 0);
      chk("rst_active", obs_active, 0);
      chk("rst_resp", respawned, 0);
      chk("rst_hit", hit, 0);

      // First spawn: seed 0xACE1 -> low 10 bits 0x0E1 = 225
      push_spawn(1'b1, 10'd225);
      reset = 1'b0;
      cyc();
      chk("spawn1_x", obs_x, 225);
      chk("spawn1_active", obs_active, 1);
      chk("spawn1_resp", respawned, 1);
      cyc();
      chk("spawn1_resp_drop", respawned, 0);

      // Movement: 10 ticks, 5 cycles apart
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("move_y", obs_y, 2 * i);
         repeat (3) cyc();
         chk("hold_y", obs_y, 2 * i);
      end
      repeat (1000) cyc();
      chk("idle_y", obs_y, 20);

      // Single-fire hit: obstacle spans y 20..35, player spans 16..31
      chk("pre_hit", hit, 0);
      player_x = obs_x + 10'd8;
      player_y = 10'd16;
      hit_q.push_back(1);
      cyc();
      chk("hit1_on", hit, 1);
      cyc();
      chk("hit1_off", hit, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("hit1_stay_off", hit, 0);
      chk("y_after_hit", obs_y, 30);
      player_away();

      // Finish the descent from y=30 to 478, then retire
      for (int i = 0; i < 224; i++) tick();
      chk("y_at_478", obs_y, 478);
      tick();
      chk("retire_active", obs_active, 0);
      chk("retire_y", obs_y, 0);
      gap_and_respawn("pass2");

      // A player touching the right edge does not count as an overlap; one pixel further in does
      player_x = obs_x + 10'd32;
      player_y = obs_y;
      repeat (5) cyc();
      chk("abut_no_hit", hit, 0);
      player_x = obs_x + 10'd31;
      hit_q.push_back(1);
      cyc();
      chk("hit2_on", hit, 1);
      cyc();
      chk("hit2_off", hit, 0);
      player_away();

      // Reset during WAIT, with a tick on the reset edge
      retire_from_top();
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      move_followers = 1'b1;
      cyc();
      move_followers = 1'b0;
      cyc();
      chk("rst2_x", obs_x, 0);
      chk("rst2_y", obs_y, 0);
      chk("rst2_active", obs_active, 0);
      chk("rst2_resp", respawned, 0);
      chk("rst2_hit", hit, 0);
      push_spawn(1'b1, 10'd225);
      reset = 1'b0;
      cyc();
      chk("spawn3_x", obs_x, 225);
      chk("spawn3_active", obs_active, 1);
      chk("spawn3_resp", respawned, 1);

      // The full gap must run again; nothing left over from before the reset
      retire_from_top();
      gap_and_respawn("pass4");

      repeat (3) cyc();
      chk("spawn_q_empty", sp_q.size(), 0);
      chk("hit_q_empty", hit_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
